// File: rtl/utopia_atm_tx_p.sv
// UTOPIA ATM cell transmitter: captures one 53-octet cell per request and streams it to the PHY.
// Optional feature: define UTOPIA_TX_HEC_GEN_EN to generate the HEC octet (CRC-8 ^ 8'h55) internally.
module utopia_atm_tx_p #(
  parameter int DW  = 8,
  parameter int UNI = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          soc,
  output logic [DW-1:0] data,
  output logic          en,
  input  logic          clav,
  input  logic          txreq,
  output logic          txack,
  input  logic [3:0]    gfc,
  input  logic [11:0]   vpi,
  input  logic [15:0]   vci,
  input  logic [2:0]    pt,
  input  logic          clp,
  input  logic [7:0]    hec,
  input  logic [383:0]  payload
);

  localparam int NW = (DW == 16) ? 27 : 53;
  localparam int WW = $clog2(NW);
  // The 16-bit bus pads the HEC octet with a zero, so the octet stream is one longer.
  localparam int NO = (DW == 16) ? 54 : 53;
  localparam int PO = (DW == 16) ? 6 : 5;

  if (!(DW == 8 || DW == 16)) begin : g_dw_illegal
    $error("utopia_atm_tx_p: DW must be 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, LOAD, XFER, ACK} state_t;

  typedef struct packed {
    logic [7:0]   h1;
    logic [7:0]   h2;
    logic [7:0]   h3;
    logic [7:0]   h4;
    logic [7:0]   hec;
    logic [383:0] payload;
  } cell_t;

`ifdef UTOPIA_TX_HEC_GEN_EN
  function automatic logic [7:0] hec_calc(input logic [31:0] hdr);
    logic [7:0] crc;
    logic       fb;
    crc = 8'h00;
    for (int i = 31; i >= 0; i--) begin
      fb  = crc[7] ^ hdr[i];
      crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return crc ^ 8'h55;
  endfunction
`endif

  state_t         state, state_nx;
  cell_t          cap, cap_in;
  logic [WW-1:0]  widx;
  logic [7:0]     oct   [NO];
  logic [DW-1:0]  words [NW];
  logic           last_word;
  logic           soc_d, en_d, txack_d;
  logic [DW-1:0]  data_d;

  // Fields that a given configuration leaves unread are gathered here on purpose.
  logic unused_inputs;
  assign unused_inputs = ^{gfc, vpi[11:8], hec};

  always_comb begin
    cap_in.h1      = (UNI != 0) ? {gfc, vpi[7:4]} : vpi[11:4];
    cap_in.h2      = {vpi[3:0], vci[15:12]};
    cap_in.h3      = vci[11:4];
    cap_in.h4      = {vci[3:0], pt, clp};
`ifdef UTOPIA_TX_HEC_GEN_EN
    cap_in.hec     = hec_calc({cap_in.h1, cap_in.h2, cap_in.h3, cap_in.h4});
`else
    cap_in.hec     = hec;
`endif
    cap_in.payload = payload;
  end

  // Octet stream of the captured cell in transmission order.
  always_comb begin
    for (int i = 0; i < NO; i++) oct[i] = 8'h00;
    oct[0] = cap.h1;
    oct[1] = cap.h2;
    oct[2] = cap.h3;
    oct[3] = cap.h4;
    oct[4] = cap.hec;
    for (int i = 0; i < 48; i++) oct[PO+i] = cap.payload[8*i +: 8];
  end

  if (DW == 16) begin : g_w16
    for (genvar i = 0; i < NW; i++) begin : g_word
      assign words[i] = {oct[2*i], oct[2*i+1]};
    end
  end else begin : g_w8
    for (genvar i = 0; i < NW; i++) begin : g_word
      assign words[i] = oct[i];
    end
  end

  assign last_word = (widx == WW'(NW - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: defaults first in every combinational process so no path leaves a variable unassigned (no latches).
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (txreq) state_nx = LOAD;
      LOAD: state_nx = XFER;
      XFER: if (clav && last_word) state_nx = ACK;
      ACK:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    soc_d   = 1'b0;
    en_d    = 1'b0;
    txack_d = 1'b0;
    data_d  = '0;
    unique case (state)
      XFER: begin
        if (clav) begin
          data_d = words[widx];
          en_d   = 1'b1;
          soc_d  = (widx == '0);
        end else begin
          data_d = data;
        end
      end
      ACK:     txack_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      soc   <= 1'b0;
      en    <= 1'b0;
      txack <= 1'b0;
      data  <= '0;
    end else begin
      soc   <= soc_d;
      en    <= en_d;
      txack <= txack_d;
      data  <= data_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      widx <= '0;
    end else if (state == IDLE && txreq) begin
      widx <= '0;
    end else if (state == XFER && clav && !last_word) begin
      widx <= widx + 1'b1;
    end
  end

  // NOTE: the capture register is cleared by reset so an aborted cell leaves no stale fields behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cap <= '0;
    else if (state == LOAD)  cap <= cap_in;
  end

endmodule

// File: tb/tb_utopia_atm_tx_p.sv
// Self-checking bench for utopia_atm_tx_p: one DW=8/NNI and one DW=16/UNI instance against an octet-level cell model.
module tb_utopia_atm_tx_p;

  typedef struct packed {
    logic [3:0]   gfc;
    logic [11:0]  vpi;
    logic [15:0]  vci;
    logic [2:0]   pt;
    logic         clp;
    logic [7:0]   hec;
    logic [383:0] payload;
  } cell_t;

  typedef struct {
    logic        soc;
    logic [15:0] data;
    int          cyc;
  } obs_t;

  typedef int iq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clav = 1'b1;
  logic        txreq8 = 1'b0;
  logic        txreq16 = 1'b0;
  cell_t       cur = '0;
  logic        soc8, en8, txack8, soc16, en16, txack16;
  logic [7:0]  data8;
  logic [15:0] data16;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  obs_t q8[$], q16[$];
  int   a8[$], a16[$];

  utopia_atm_tx_p #(.DW(8), .UNI(0)) u8 (
    .clk(clk), .rst_n(rst_n), .soc(soc8), .data(data8), .en(en8), .clav(clav),
    .txreq(txreq8), .txack(txack8), .gfc(cur.gfc), .vpi(cur.vpi), .vci(cur.vci),
    .pt(cur.pt), .clp(cur.clp), .hec(cur.hec), .payload(cur.payload)
  );

  utopia_atm_tx_p #(.DW(16), .UNI(1)) u16 (
    .clk(clk), .rst_n(rst_n), .soc(soc16), .data(data16), .en(en16), .clav(clav),
    .txreq(txreq16), .txack(txack16), .gfc(cur.gfc), .vpi(cur.vpi), .vci(cur.vci),
    .pt(cur.pt), .clp(cur.clp), .hec(cur.hec), .payload(cur.payload)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (en8)     q8.push_back('{soc: soc8, data: {8'h00, data8}, cyc: cyc});
    if (en16)    q16.push_back('{soc: soc16, data: data16, cyc: cyc});
    if (txack8)  a8.push_back(cyc);
    if (txack16) a16.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

`ifdef UTOPIA_TX_HEC_GEN_EN
  // CRC as the remainder of polynomial long division of header * x^8 by x^8+x^2+x+1.
  function automatic logic [7:0] crc_div(input logic [31:0] m);
    logic [39:0] r;
    r = {m, 8'h00};
    for (int i = 39; i >= 8; i--)
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    return r[7:0];
  endfunction
`endif

  function automatic iq_t model_words(input cell_t c, input int dw, input bit uni);
    logic [7:0] o[$];
    iq_t        w;
    logic [7:0] h1, h2, h3, h4, hx;
    h1 = uni ? {c.gfc, c.vpi[7:4]} : c.vpi[11:4];
    h2 = {c.vpi[3:0], c.vci[15:12]};
    h3 = c.vci[11:4];
    h4 = {c.vci[3:0], c.pt, c.clp};
`ifdef UTOPIA_TX_HEC_GEN_EN
    hx = crc_div({h1, h2, h3, h4}) ^ 8'h55;
`else
    hx = c.hec;
`endif
    o.push_back(h1); o.push_back(h2); o.push_back(h3); o.push_back(h4); o.push_back(hx);
    if (dw == 16) o.push_back(8'h00);
    for (int i = 0; i < 48; i++) o.push_back(c.payload[8*i +: 8]);
    if (dw == 8) begin
      foreach (o[i]) w.push_back(int'(o[i]));
    end else begin
      for (int i = 0; i + 1 < o.size(); i += 2) w.push_back(int'({o[i], o[i+1]}));
    end
    return w;
  endfunction

  function automatic cell_t rand_cell();
    cell_t c;
    c.gfc = 4'($urandom());
    c.vpi = 12'($urandom());
    c.vci = 16'($urandom());
    c.pt  = 3'($urandom());
    c.clp = 1'($urandom());
    c.hec = 8'($urandom());
    for (int i = 0; i < 12; i++) c.payload[32*i +: 32] = $urandom();
    return c;
  endfunction

  // Requests ncells cells on one instance and drives clav/fields until the acks arrive (bounded).
  task automatic run_cell(input bit use16, input int ncells, input bit rand_clav, input int stall_at,
                          input int abort_at, input int swap_at, input cell_t nxt, output int t0);
    bit          drop = (ncells == 1);
    bit          done = 1'b0;
    bit          stalled = 1'b0;
    bit          swapped = 1'b0;
    int          stall_left = 0;
    int          nq, na;
    logic [15:0] frozen = '0;
    q8.delete(); q16.delete(); a8.delete(); a16.delete();
    @(negedge clk); #1;
    t0 = cyc;
    if (use16) txreq16 = 1'b1; else txreq8 = 1'b1;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk); #1;
      nq = use16 ? q16.size() : q8.size();
      na = use16 ? a16.size() : a8.size();
      if (drop) begin txreq8 = 1'b0; txreq16 = 1'b0; end
      if (na >= ncells - 1) drop = 1'b1;
      if (na >= ncells) begin done = 1'b1; break; end
      if (ncells == 1 && k == 1) cur = rand_cell();
      if (nq == swap_at && !swapped) begin cur = nxt; swapped = 1'b1; end
      if (stall_left > 0) begin
        check("stall_en", use16 ? en16 : en8, 1'b0);
        check("stall_data", use16 ? data16 : {8'h00, data8}, frozen);
        stall_left--;
        if (stall_left == 0) clav = 1'b1;
      end else if (nq == stall_at && !stalled) begin
        clav = 1'b0;
        stall_left = 3;
        stalled = 1'b1;
        frozen = use16 ? data16 : {8'h00, data8};
      end else if (rand_clav) begin
        clav = ($urandom_range(0, 3) != 0);
      end
      if (nq == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_soc", use16 ? soc16 : soc8, 1'b0);
        check("abort_en", use16 ? en16 : en8, 1'b0);
        check("abort_data", use16 ? data16 : {8'h00, data8}, 0);
        check("abort_txack", use16 ? txack16 : txack8, 1'b0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        done = 1'b1;
        break;
      end
    end
    clav = 1'b1;
    txreq8 = 1'b0;
    txreq16 = 1'b0;
    check("cell_done", done, 1'b1);
  endtask

  task automatic verify(input bit use16, input iq_t exp, input int ncells, input int t0,
                        input bit chk_lat, input string tag);
    obs_t q[$];
    int   a[$];
    int   nw = use16 ? 27 : 53;
    repeat (5) @(negedge clk);
    if (use16) begin q = q16; a = a16; end else begin q = q8; a = a8; end
    check({tag, "_count"}, q.size(), exp.size());
    for (int i = 0; i < q.size() && i < exp.size(); i++) begin
      check($sformatf("%s_w%0d", tag, i), q[i].data, exp[i]);
      check($sformatf("%s_soc%0d", tag, i), q[i].soc, (i % nw) == 0);
    end
    check({tag, "_acks"}, a.size(), ncells);
    for (int k = 0; k < a.size() && k < ncells; k++)
      if ((k + 1) * nw - 1 < q.size())
        check($sformatf("%s_ack%0d_cyc", tag, k), a[k], q[(k + 1) * nw - 1].cyc + 1);
    if (chk_lat && q.size() > 0) check({tag, "_latency"}, q[0].cyc, t0 + 3);
    if (ncells == 2 && a.size() > 0 && q.size() > nw)
      check({tag, "_b2b_soc"}, q[nw].cyc, a[0] + 3);
  endtask

  initial begin
    cell_t c, c2;
    iq_t   e, e2;
    int    t0;

    // Reset state, with a request asserted that must be ignored.
    txreq8 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_soc8", soc8, 1'b0);
    check("rst_en8", en8, 1'b0);
    check("rst_data8", data8, 8'h00);
    check("rst_txack8", txack8, 1'b0);
    check("rst_soc16", soc16, 1'b0);
    check("rst_en16", en16, 1'b0);
    check("rst_data16", data16, 16'h0000);
    check("rst_txack16", txack16, 1'b0);
    txreq8 = 1'b0;
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // NNI 8-bit reference header.
    c = rand_cell();
    c.vpi = 12'hABC; c.vci = 16'h1234; c.pt = 3'b010; c.clp = 1'b1;
    cur = c;
    e = model_words(c, 8, 1'b0);
    run_cell(1'b0, 1, 1'b0, -1, -1, -1, c, t0);
    verify(1'b0, e, 1, t0, 1'b1, "nni8");
    if (q8.size() >= 4) begin
      check("nni8_h1", q8[0].data, 16'h00AB);
      check("nni8_h2", q8[1].data, 16'h00C1);
      check("nni8_h3", q8[2].data, 16'h0023);
      check("nni8_h4", q8[3].data, 16'h0045);
    end

    // UNI 16-bit reference header.
    c = rand_cell();
    c.gfc = 4'h5; c.vpi[7:0] = 8'h6A; c.vci[15:12] = 4'h1; c.hec = 8'h77;
    cur = c;
    e = model_words(c, 16, 1'b1);
    run_cell(1'b1, 1, 1'b0, -1, -1, -1, c, t0);
    verify(1'b1, e, 1, t0, 1'b1, "uni16");
    check("uni16_en_cycles", q16.size(), 27);
    if (q16.size() >= 3) begin
      check("uni16_w0", q16[0].data, 16'h56A1);
`ifdef UTOPIA_TX_HEC_GEN_EN
      check("uni16_w2", q16[2].data, e[2]);
`else
      check("uni16_w2", q16[2].data, 16'h7700);
`endif
    end

    // All-zero header, then H4 = 01.
    for (int v = 0; v < 2; v++) begin
      c = rand_cell();
      c.gfc = 4'h0; c.vpi = 12'h000; c.vci = 16'h0000; c.pt = 3'b000; c.clp = 1'(v);
      cur = c;
      e = model_words(c, 8, 1'b0);
      run_cell(1'b0, 1, 1'b0, -1, -1, -1, c, t0);
      verify(1'b0, e, 1, t0, 1'b1, $sformatf("zhdr%0d", v));
      if (q8.size() >= 5) begin
`ifdef UTOPIA_TX_HEC_GEN_EN
        check($sformatf("zhdr%0d_hec", v), q8[4].data, (v == 0) ? 16'h0055 : 16'h0052);
`else
        check($sformatf("zhdr%0d_hec", v), q8[4].data, {8'h00, c.hec});
`endif
      end
    end

    // clav low for three cycles with widx at 10.
    c = rand_cell();
    cur = c;
    e = model_words(c, 8, 1'b0);
    run_cell(1'b0, 1, 1'b0, 10, -1, -1, c, t0);
    verify(1'b0, e, 1, t0, 1'b1, "stall");
    if (q8.size() >= 11) check("stall_gap", q8[10].cyc - q8[9].cyc, 4);

    // Reset pulse at widx 20, then a fresh cell.
    c = rand_cell();
    cur = c;
    run_cell(1'b0, 1, 1'b0, -1, 20, -1, c, t0);
    repeat (10) @(negedge clk);
    check("abort_no_ack", a8.size(), 0);
    check("abort_words", q8.size(), 20);
    check("abort_idle_en", en8, 1'b0);
    c = rand_cell();
    cur = c;
    e = model_words(c, 8, 1'b0);
    run_cell(1'b0, 1, 1'b0, -1, -1, -1, c, t0);
    verify(1'b0, e, 1, t0, 1'b1, "post_abort");

    // Back-to-back cells with a payload change during the first.
    c = rand_cell();
    c2 = c;
    for (int i = 0; i < 12; i++) c2.payload[32*i +: 32] = $urandom();
    cur = c;
    e = model_words(c, 8, 1'b0);
    e2 = model_words(c2, 8, 1'b0);
    foreach (e2[i]) e.push_back(e2[i]);
    run_cell(1'b0, 2, 1'b0, -1, -1, 30, c2, t0);
    verify(1'b0, e, 2, t0, 1'b1, "b2b");

    // Random cells with random clav on both instances.
    for (int n = 0; n < 4; n++) begin
      c = rand_cell();
      cur = c;
      e = model_words(c, (n % 2) ? 16 : 8, n % 2 == 1);
      run_cell(n % 2 == 1, 1, 1'b1, -1, -1, -1, c, t0);
      verify(n % 2 == 1, e, 1, t0, 1'b0, $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
